// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART transmit and receive paths.
//   tx_state_t        : transmitter FSM states
//   FRAME_BITS        : bits per frame, including start and stop
//                       (10, or 11 when UART_TX_PARITY_EN adds a parity bit)
//   symbol_edge_time(): core clock cycles per serial bit
// ---------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } tx_state_t;

`ifdef UART_TX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif

    // Integer division: any fractional part of the ratio is dropped, so the
    // bit period rounds down toward a slightly faster line rate.
    function automatic int symbol_edge_time(input int clock_freq, input int baud_rate);
        return clock_freq / baud_rate;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// ---------------------------------------------------------------------------
// uart_tx_fifo
// Synchronous FIFO that sits between the CPU write path and the serializer.
// Ports:
//   clk, rst   : core clock, asynchronous active-high reset
//   push       : write push_data (ignored when full)
//   push_data  : entry to write
//   pop        : drop the head entry (ignored when empty)
//   pop_data   : current head entry, valid whenever empty is low
//   full/empty : occupancy flags
//   count      : number of entries held
// DEPTH must be a power of two so the pointers wrap for free.
// ---------------------------------------------------------------------------
module uart_tx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    // Storage needs no reset: an entry is only ever read after it was written.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers and count; a simultaneous push and pop leaves the count alone.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (do_push && !do_pop) begin
                count <= count + CNT_W'(1);
            end else if (do_pop && !do_push) begin
                count <= count - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/uart_tx_buffered.sv
// ---------------------------------------------------------------------------
// uart_tx_buffered
// Buffered 8N1 UART transmitter. The CPU hands bytes over with ready/valid
// into a small FIFO; the FSM below serializes them LSB first.
// Ports:
//   clk, rst      : core clock, asynchronous active-high reset
//   data_in       : byte to transmit
//   data_in_valid : producer presents data_in
//   data_in_ready : FIFO can accept (transfer when valid && ready at posedge)
//   serial_out    : UART line, idles high
//   tx_busy       : frame on the line or bytes waiting in the FIFO
//   fifo_count    : bytes in the FIFO (not counting the one being shifted)
// Build option:
//   UART_TX_PARITY_EN : insert an even-parity bit between d[7] and stop
// ---------------------------------------------------------------------------
module uart_tx_buffered
    import uart_pkg::*;
#(
    parameter int CLOCK_FREQ = 50_000_000,
    parameter int BAUD_RATE  = 10_000_000,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [7:0]                    data_in,
    input  logic                          data_in_valid,
    output logic                          data_in_ready,
    output logic                          serial_out,
    output logic                          tx_busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int SYMBOL_EDGE_TIME = symbol_edge_time(CLOCK_FREQ, BAUD_RATE);
    localparam int BAUD_W = (SYMBOL_EDGE_TIME > 1) ? $clog2(SYMBOL_EDGE_TIME) : 1;
    localparam int BIT_W  = $clog2(FRAME_BITS);

    tx_state_t             state;
    logic [FRAME_BITS-1:0] shift_reg;
    logic [FRAME_BITS-1:0] next_frame;
    logic [BAUD_W-1:0]     baud_cnt;
    logic [BIT_W-1:0]      bit_idx;
    logic                  ready_en;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [7:0]            fifo_head;
    logic                  push;
    logic                  pop;
    logic                  baud_done;
    logic                  frame_done;

    uart_tx_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (data_in),
        .pop       (pop),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Frame laid out LSB first so the line is always shift_reg[0].
`ifdef UART_TX_PARITY_EN
    assign next_frame = {1'b1, ^fifo_head, fifo_head, 1'b0};
`else
    assign next_frame = {1'b1, fifo_head, 1'b0};
`endif

    assign baud_done  = (baud_cnt == BAUD_W'(SYMBOL_EDGE_TIME - 1));
    assign frame_done = baud_done && (bit_idx == BIT_W'(FRAME_BITS - 1));

    // The FSM pops when idle, or at the very end of a stop bit so the next
    // start bit follows with no gap.
    assign pop        = !fifo_empty && ((state == IDLE) || frame_done);
    assign data_in_ready = ready_en && !fifo_full;
    assign push       = data_in_valid && data_in_ready;
    assign serial_out = shift_reg[0];
    assign tx_busy    = (state != IDLE) || !fifo_empty;

    // Holds ready low while reset is asserted and for the rest of that cycle,
    // so the producer sees ready rise on the first edge after release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ready_en <= 1'b0;
        end else begin
            ready_en <= 1'b1;
        end
    end

    // Transmit FSM and shift register. Shifting fills with ones, so the line
    // is already high when a frame finishes and the FSM drops back to IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            shift_reg <= '1;
            baud_cnt  <= '0;
            bit_idx   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!fifo_empty) begin
                        shift_reg <= next_frame;
                        baud_cnt  <= '0;
                        bit_idx   <= '0;
                        state     <= SEND;
                    end
                end
                SEND: begin
                    if (!baud_done) begin
                        baud_cnt <= baud_cnt + BAUD_W'(1);
                    end else begin
                        baud_cnt <= '0;
                        if (frame_done && !fifo_empty) begin
                            shift_reg <= next_frame;
                            bit_idx   <= '0;
                        end else if (frame_done) begin
                            shift_reg <= {1'b1, shift_reg[FRAME_BITS-1:1]};
                            bit_idx   <= '0;
                            state     <= IDLE;
                        end else begin
                            shift_reg <= {1'b1, shift_reg[FRAME_BITS-1:1]};
                            bit_idx   <= bit_idx + BIT_W'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_buffered
// Directed self-checking bench for uart_tx_buffered at 50 MHz / 10 Mbit/s
// (5 clocks per bit). Inputs change and outputs are sampled on negedge.
// Honours UART_TX_PARITY_EN for the frame length and parity checks.
// ---------------------------------------------------------------------------
module tb_uart_tx_buffered;

    localparam int S = 5;
`ifdef UART_TX_PARITY_EN
    localparam int FB = 11;
`else
    localparam int FB = 10;
`endif

    logic       clk;
    logic       rst;
    logic [7:0] data_in;
    logic       data_in_valid;
    logic       data_in_ready;
    logic       serial_out;
    logic       tx_busy;
    logic [2:0] fifo_count;

    int errors = 0;
    int checks = 0;
    int mon_err = 0;
    logic [7:0] rx_q[$];

    uart_tx_buffered #(
        .CLOCK_FREQ (50_000_000),
        .BAUD_RATE  (10_000_000),
        .FIFO_DEPTH (4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .data_in       (data_in),
        .data_in_valid (data_in_valid),
        .data_in_ready (data_in_ready),
        .serial_out    (serial_out),
        .tx_busy       (tx_busy),
        .fifo_count    (fifo_count)
    );

    // Free-running core clock, period 10 time units.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Watchdog so a stuck design still ends the run.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation still running, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Serial monitor: finds a start bit, samples each bit at its middle and
    // queues the decoded byte.
    initial begin
        logic [7:0] b;
        logic       par;
        forever begin
            @(negedge clk);
            if (rst === 1'b0 && serial_out === 1'b0) begin
                repeat (2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (S) @(negedge clk);
                    b[i] = serial_out;
                end
`ifdef UART_TX_PARITY_EN
                repeat (S) @(negedge clk);
                par = serial_out;
                if (par !== ^b) mon_err++;
`else
                par = 1'b0;
`endif
                repeat (S) @(negedge clk);
                if (serial_out !== 1'b1) mon_err++;
                rx_q.push_back(b);
            end
        end
    end

    function automatic logic frame_bit(input logic [7:0] b, input int i);
        if (i == 0) return 1'b0;
        if (i <= 8) return b[i-1];
        if (i == FB - 1) return 1'b1;
        return ^b;
    endfunction

    // Expected line at negedge N+k for frames starting at edge N+1 back to back.
    function automatic logic exp_line(input logic [7:0] b0, input logic [7:0] b1,
                                      input int nbytes, input int k);
        int idx;
        int f;
        if (k < 1) return 1'b1;
        idx = k - 1;
        f   = idx / (FB * S);
        if (f >= nbytes) return 1'b1;
        return frame_bit((f == 0) ? b0 : b1, (idx % (FB * S)) / S);
    endfunction

    // Presents a byte and waits (bounded) until it is accepted; returns at the
    // negedge just after the accepting edge.
    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        @(negedge clk);
        data_in       = b;
        data_in_valid = 1'b1;
        while (data_in_ready !== 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 2000) begin
            errors++;
            $display("[TB] FAIL send_timeout: ready never rose for byte %02h", b);
        end
        @(negedge clk);
        data_in_valid = 1'b0;
    endtask

    task automatic wait_idle(input int bound, input string name);
        int n = 0;
        while (tx_busy !== 1'b0 && n < bound) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= bound) begin
            errors++;
            $display("[TB] FAIL %s: tx_busy still %b after %0d cycles, expected 0", name, tx_busy, bound);
        end
    endtask

    task automatic test_reset();
        #2;
        checks++; if (serial_out !== 1'b1) begin errors++; $display("[TB] FAIL rst_line: got %b expected 1", serial_out); end
        checks++; if (data_in_ready !== 1'b0) begin errors++; $display("[TB] FAIL rst_ready: got %b expected 0", data_in_ready); end
        checks++; if (tx_busy !== 1'b0) begin errors++; $display("[TB] FAIL rst_busy: got %b expected 0", tx_busy); end
        checks++; if (fifo_count !== 3'd0) begin errors++; $display("[TB] FAIL rst_count: got %0d expected 0", fifo_count); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if (data_in_ready !== 1'b0) begin errors++; $display("[TB] FAIL release_ready: got %b expected 0", data_in_ready); end
        @(negedge clk);
        checks++; if (data_in_ready !== 1'b1) begin errors++; $display("[TB] FAIL first_edge_ready: got %b expected 1", data_in_ready); end
    endtask

    task automatic test_single(input logic [7:0] b);
        logic       line_s [0:79];
        logic       busy_s [0:79];
        logic [2:0] cnt0;
        logic [2:0] cnt1;
        int         last;
        last = FB * S + 5;
        rx_q.delete();
        send_byte(b);
        cnt0 = fifo_count;
        cnt1 = '0;
        for (int k = 0; k <= last; k++) begin
            line_s[k] = serial_out;
            busy_s[k] = tx_busy;
            if (k == 1) cnt1 = fifo_count;
            @(negedge clk);
        end
        checks++; if (cnt0 !== 3'd1) begin errors++; $display("[TB] FAIL single_count_push: got %0d expected 1", cnt0); end
        checks++; if (cnt1 !== 3'd0) begin errors++; $display("[TB] FAIL single_count_pop: got %0d expected 0", cnt1); end
        for (int k = 0; k <= last; k++) begin
            checks++;
            if (line_s[k] !== exp_line(b, 8'h00, 1, k)) begin
                errors++;
                $display("[TB] FAIL single_line byte %02h cycle N+%0d: got %b expected %b", b, k, line_s[k], exp_line(b, 8'h00, 1, k));
            end
            checks++;
            if (busy_s[k] !== (k <= FB * S)) begin
                errors++;
                $display("[TB] FAIL single_busy byte %02h cycle N+%0d: got %b expected %b", b, k, busy_s[k], (k <= FB * S));
            end
        end
        checks++;
        if (rx_q.size() != 1 || rx_q[0] !== b) begin
            errors++;
            $display("[TB] FAIL single_decode: got %0d bytes first %02h expected 1 byte %02h", rx_q.size(), (rx_q.size() > 0) ? rx_q[0] : 8'hxx, b);
        end
    endtask

    task automatic test_back_to_back();
        logic line_s [0:127];
        int   last;
        last = 2 * FB * S + 4;
        rx_q.delete();
        @(negedge clk);
        data_in = 8'h48; data_in_valid = 1'b1;
        @(negedge clk);
        data_in = 8'h69;
        @(negedge clk);
        data_in_valid = 1'b0;
        for (int k = 1; k <= last; k++) begin
            line_s[k] = serial_out;
            @(negedge clk);
        end
        for (int k = 1; k <= last; k++) begin
            checks++;
            if (line_s[k] !== exp_line(8'h48, 8'h69, 2, k)) begin
                errors++;
                $display("[TB] FAIL b2b_line cycle N+%0d: got %b expected %b", k, line_s[k], exp_line(8'h48, 8'h69, 2, k));
            end
        end
        checks++; if (line_s[FB*S+1] !== 1'b0) begin errors++; $display("[TB] FAIL b2b_no_gap: got %b expected 0", line_s[FB*S+1]); end
        checks++;
        if (rx_q.size() != 2 || rx_q[0] !== 8'h48 || rx_q[1] !== 8'h69) begin
            errors++;
            $display("[TB] FAIL b2b_decode: got %0d bytes expected 48 69", rx_q.size());
        end
        wait_idle(200, "b2b_idle");
    endtask

    task automatic test_full_fifo();
        int acc = 0;
        logic [7:0] exp_b [0:5];
        rx_q.delete();
        @(negedge clk);
        data_in = 8'h10; data_in_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (data_in_ready === 1'b1) acc++;
            @(negedge clk);
            data_in = 8'h10 + 8'(acc);
        end
        data_in_valid = 1'b0;
        checks++; if (acc != 5) begin errors++; $display("[TB] FAIL full_accepted: got %0d expected 5", acc); end
        checks++; if (data_in_ready !== 1'b0) begin errors++; $display("[TB] FAIL full_ready: got %b expected 0", data_in_ready); end
        checks++; if (fifo_count !== 3'd4) begin errors++; $display("[TB] FAIL full_count: got %0d expected 4", fifo_count); end
        repeat (FB * S - 7) @(negedge clk);
        checks++; if (fifo_count !== 3'd4) begin errors++; $display("[TB] FAIL full_hold_count: got %0d expected 4", fifo_count); end
        checks++; if (data_in_ready !== 1'b0) begin errors++; $display("[TB] FAIL full_hold_ready: got %b expected 0", data_in_ready); end
        @(negedge clk);
        checks++; if (fifo_count !== 3'd3) begin errors++; $display("[TB] FAIL full_pop_count: got %0d expected 3", fifo_count); end
        checks++; if (data_in_ready !== 1'b1) begin errors++; $display("[TB] FAIL full_pop_ready: got %b expected 1", data_in_ready); end
        data_in = 8'h99; data_in_valid = 1'b1;
        @(negedge clk);
        data_in_valid = 1'b0;
        checks++; if (fifo_count !== 3'd4) begin errors++; $display("[TB] FAIL full_refill_count: got %0d expected 4", fifo_count); end
        checks++; if (data_in_ready !== 1'b0) begin errors++; $display("[TB] FAIL full_refill_ready: got %b expected 0", data_in_ready); end
        wait_idle(1000, "full_idle");
        repeat (5) @(negedge clk);
        exp_b = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h99};
        checks++; if (rx_q.size() != 6) begin errors++; $display("[TB] FAIL full_decode_len: got %0d expected 6", rx_q.size()); end
        for (int i = 0; i < 6 && i < rx_q.size(); i++) begin
            checks++;
            if (rx_q[i] !== exp_b[i]) begin errors++; $display("[TB] FAIL full_decode[%0d]: got %02h expected %02h", i, rx_q[i], exp_b[i]); end
        end
    endtask

    task automatic test_reset_mid_frame();
        send_byte(8'hFF);
        send_byte(8'h00);
        send_byte(8'h00);
        repeat (19) @(negedge clk);
        checks++; if (fifo_count !== 3'd2) begin errors++; $display("[TB] FAIL mid_pre_count: got %0d expected 2", fifo_count); end
        checks++; if (tx_busy !== 1'b1) begin errors++; $display("[TB] FAIL mid_pre_busy: got %b expected 1", tx_busy); end
        #2;
        rst = 1'b1;
        #1;
        checks++; if (serial_out !== 1'b1) begin errors++; $display("[TB] FAIL mid_rst_line: got %b expected 1", serial_out); end
        checks++; if (fifo_count !== 3'd0) begin errors++; $display("[TB] FAIL mid_rst_count: got %0d expected 0", fifo_count); end
        checks++; if (tx_busy !== 1'b0) begin errors++; $display("[TB] FAIL mid_rst_busy: got %b expected 0", tx_busy); end
        checks++; if (data_in_ready !== 1'b0) begin errors++; $display("[TB] FAIL mid_rst_ready: got %b expected 0", data_in_ready); end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (60) @(negedge clk);
        checks++; if (serial_out !== 1'b1) begin errors++; $display("[TB] FAIL mid_after_line: got %b expected 1", serial_out); end
        checks++; if (tx_busy !== 1'b0) begin errors++; $display("[TB] FAIL mid_after_busy: got %b expected 0", tx_busy); end
        test_single(8'h55);
    endtask

`ifdef UART_TX_PARITY_EN
    task automatic test_parity();
        logic [7:0] pb [0:1];
        logic       pe [0:1];
        pb = '{8'h07, 8'h03};
        pe = '{1'b1, 1'b0};
        for (int i = 0; i < 2; i++) begin
            send_byte(pb[i]);
            repeat (1 + 9 * S + 2) @(negedge clk);
            checks++;
            if (serial_out !== pe[i]) begin
                errors++;
                $display("[TB] FAIL parity_bit byte %02h: got %b expected %b", pb[i], serial_out, pe[i]);
            end
            wait_idle(200, "parity_idle");
        end
        test_single(8'h07);
        test_single(8'h03);
    endtask
`endif

    task automatic test_host_loop();
        string s;
        int    err0;
        s    = "41c00000\r\n";
        err0 = mon_err;
        rx_q.delete();
        for (int i = 0; i < s.len(); i++) begin
            send_byte(s[i]);
        end
        wait_idle(2000, "host_idle");
        repeat (5) @(negedge clk);
        checks++; if (rx_q.size() != s.len()) begin errors++; $display("[TB] FAIL host_len: got %0d expected %0d", rx_q.size(), s.len()); end
        for (int i = 0; i < s.len() && i < rx_q.size(); i++) begin
            checks++;
            if (rx_q[i] !== s[i]) begin errors++; $display("[TB] FAIL host_char[%0d]: got %02h expected %02h", i, rx_q[i], s[i]); end
        end
        checks++; if (mon_err != err0) begin errors++; $display("[TB] FAIL host_framing: got %0d framing errors expected 0", mon_err - err0); end
    endtask

    // Runs every scenario in order, then prints the summary.
    initial begin
        rst           = 1'b1;
        data_in       = 8'h00;
        data_in_valid = 1'b0;
        test_reset();
        $display("[TB] single byte");
        test_single(8'h41);
        $display("[TB] back to back");
        test_back_to_back();
        $display("[TB] full fifo");
        test_full_fifo();
        $display("[TB] reset mid frame");
        test_reset_mid_frame();
`ifdef UART_TX_PARITY_EN
        $display("[TB] parity");
        test_parity();
`endif
        $display("[TB] host loop");
        test_host_loop();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
